// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction size and the all-zero end-of-program word.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_out_reg.sv
// Valid/ready output register toward decode: captures a fetched word,
// holds it under back-pressure and drops it on a flush.
module fetch_out_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid,
  output logic        slot_free
);

  assign slot_free = !valid || ready;

  // Flush wins over both a new capture and a completing handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      instr <= next_instr;
      pc    <= next_pc;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, samples the instruction memory into the output
// register and stops on end-of-program or an out-of-range fetch.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 32,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        halted_o,
  output logic [15:0] fetch_count_o
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'(INSTR_BYTES);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic         halted_reg;
  logic [15:0]  fetch_count_reg;

  logic slot_free;
  logic redirect_take;
  logic in_range;
  logic zero_stop;
  logic fetching;
  logic capture;
  logic stop;
  logic handoff;

  // A redirect during the post-reset IDLE cycle is deliberately dropped.
  assign redirect_take = redirect_i && (state_reg != ST_IDLE);
  assign in_range      = {1'b0, pc_reg} < IMEM_BYTES;
  assign zero_stop     = HALT_ON_ZERO && (instr_i == NOP_INSTR);
  assign fetching      = (state_reg == ST_FETCH) && !redirect_take && slot_free;
  assign capture       = fetching && in_range && !zero_stop;
  assign stop          = fetching && !capture;
  assign handoff       = valid_o && ready_i && !redirect_take;

  fetch_out_reg u_out_reg (
    .clk        (clk_i),
    .rst        (rst_i),
    .capture    (capture),
    .flush      (redirect_take),
    .ready      (ready_i),
    .next_instr (instr_i),
    .next_pc    (pc_reg),
    .instr      (instr_o),
    .pc         (pc_o),
    .valid      (valid_o),
    .slot_free  (slot_free)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: state_reg <= ST_FETCH;
        ST_FETCH, ST_HALT: begin
          if (redirect_take) begin
            pc_reg     <= align_word(redirect_pc_i);
            halted_reg <= 1'b0;
            state_reg  <= ST_FETCH;
          end else if (stop) begin
            halted_reg <= 1'b1;
            state_reg  <= ST_HALT;
          end else if (capture) begin
            pc_reg <= pc_reg + 32'(INSTR_BYTES);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_count_reg <= '0;
    end else if (handoff && (fetch_count_reg != 16'hFFFF)) begin
      fetch_count_reg <= fetch_count_reg + 16'd1;
    end
  end

  assign pc_addr_o     = pc_reg;
  assign halted_o      = halted_reg;
  assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// back-pressure runs checked against a program-order handoff scoreboard.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc_addr, instr_in, redirect_pc, instr_out, pc_out;
  logic        redirect, valid, ready, halted;
  logic [15:0] count;

  logic [31:0] pc_addr_s, instr_in_s, redirect_pc_s, instr_out_s, pc_out_s;
  logic        redirect_s, valid_s, ready_s, halted_s;
  logic [15:0] count_s;

  logic [31:0] mem   [32];
  logic [31:0] mem_s [4];
  logic [31:0] prog  [3] = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820};

  int checks = 0;
  int errors = 0;

  assign instr_in   = (pc_addr   < 32'd128) ? mem[pc_addr[6:2]]     : 32'hFFFF_FFFF;
  assign instr_in_s = (pc_addr_s < 32'd16)  ? mem_s[pc_addr_s[3:2]] : 32'hFFFF_FFFF;

  instr_fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .pc_addr_o(pc_addr), .instr_i(instr_in),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_o(instr_out),
    .pc_o(pc_out), .valid_o(valid), .ready_i(ready), .halted_o(halted),
    .fetch_count_o(count)
  );

  instr_fetch_unit #(.IMEM_WORDS(4), .HALT_ON_ZERO(1'b0)) dut_s (
    .clk_i(clk), .rst_i(rst), .pc_addr_o(pc_addr_s), .instr_i(instr_in_s),
    .redirect_i(redirect_s), .redirect_pc_i(redirect_pc_s), .instr_o(instr_out_s),
    .pc_o(pc_out_s), .valid_o(valid_s), .ready_i(ready_s), .halted_o(halted_s),
    .fetch_count_o(count_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_s = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_random;
    for (int i = 0; i < 32; i++) mem[i] = $urandom() | 32'h1;
    for (int i = 0; i < 4; i++) mem_s[i] = $urandom() | 32'h1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++; if (pc_addr !== 32'h0) begin errors++; $display("FAIL reset_pc_addr got %h want 00000000", pc_addr); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 00000000", instr_out); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_o got %h want 00000000", pc_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", count); end
  endtask

  task automatic test_program;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 3; i++) mem[i] = prog[i];
    ready = 1'b1;
    apply_reset();
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prog_idle_valid got %b want 0", valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid !== 1'b1 || pc_out !== 32'(4 * i) || instr_out !== prog[i]) begin
        errors++; $display("FAIL prog_out%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                           i, valid, pc_out, instr_out, 32'(4 * i), prog[i]);
      end
    end
    tick();
    checks++; if (halted !== 1'b1 || valid !== 1'b0 || pc_addr !== 32'd12) begin
      errors++; $display("FAIL prog_halt got h=%b v=%b pc_addr=%h want h=1 v=0 pc_addr=0000000c", halted, valid, pc_addr);
    end
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL prog_count got %0d want 3", count); end
    tick();
    checks++; if (halted !== 1'b1 || pc_addr !== 32'd12 || count !== 16'd3) begin
      errors++; $display("FAIL prog_hold got h=%b pc_addr=%h cnt=%0d want h=1 pc_addr=0000000c cnt=3", halted, pc_addr, count);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 3; i++) mem[i] = prog[i];
    ready = 1'b1;
    apply_reset();
    tick(); tick(); tick();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (instr_out !== prog[1] || pc_out !== 32'd4 || valid !== 1'b1 || pc_addr !== 32'd8) begin
        errors++; $display("FAIL stall%0d got instr=%h pc=%h v=%b pc_addr=%h want instr=%h pc=00000004 v=1 pc_addr=00000008",
                           k, instr_out, pc_out, valid, pc_addr, prog[1]);
      end
    end
    ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'd8 || instr_out !== prog[2] || count !== 16'd2) begin
      errors++; $display("FAIL stall_resume got pc=%h instr=%h cnt=%0d want pc=00000008 instr=%h cnt=2", pc_out, instr_out, count, prog[2]);
    end
  endtask

  task automatic test_redirect;
    fill_random();
    ready = 1'b1;
    apply_reset();
    tick(); tick(); tick(); tick();
    checks++; if (valid !== 1'b1 || pc_out !== 32'd8 || count !== 16'd2) begin
      errors++; $display("FAIL redir_pre got v=%b pc=%h cnt=%0d want v=1 pc=00000008 cnt=2", valid, pc_out, count);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_000E;
    tick();
    redirect = 1'b0;
    checks++; if (valid !== 1'b0 || pc_addr !== 32'h0C || count !== 16'd2) begin
      errors++; $display("FAIL redir_flush got v=%b pc_addr=%h cnt=%0d want v=0 pc_addr=0000000c cnt=2", valid, pc_addr, count);
    end
    tick();
    checks++; if (valid !== 1'b1 || pc_out !== 32'h0C || instr_out !== mem[3] || count !== 16'd2) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h instr=%h cnt=%0d want v=1 pc=0000000c instr=%h cnt=2",
                         valid, pc_out, instr_out, count, mem[3]);
    end
  endtask

  task automatic test_small_range;
    fill_random();
    ready_s = 1'b1;
    apply_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (valid_s !== 1'b1 || pc_out_s !== 32'(4 * i) || instr_out_s !== mem_s[i]) begin
        errors++; $display("FAIL small_out%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                           i, valid_s, pc_out_s, instr_out_s, 32'(4 * i), mem_s[i]);
      end
    end
    tick();
    checks++; if (halted_s !== 1'b1 || pc_addr_s !== 32'd16 || valid_s !== 1'b0 || count_s !== 16'd4) begin
      errors++; $display("FAIL small_halt got h=%b pc_addr=%h v=%b cnt=%0d want h=1 pc_addr=00000010 v=0 cnt=4",
                         halted_s, pc_addr_s, valid_s, count_s);
    end
    redirect_s = 1'b1;
    redirect_pc_s = 32'h0000_0002;
    tick();
    redirect_s = 1'b0;
    checks++; if (halted_s !== 1'b0 || pc_addr_s !== 32'h0 || valid_s !== 1'b0) begin
      errors++; $display("FAIL small_redir got h=%b pc_addr=%h v=%b want h=0 pc_addr=00000000 v=0", halted_s, pc_addr_s, valid_s);
    end
    tick();
    checks++; if (valid_s !== 1'b1 || pc_out_s !== 32'h0 || instr_out_s !== mem_s[0]) begin
      errors++; $display("FAIL small_resume got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=%h", valid_s, pc_out_s, instr_out_s, mem_s[0]);
    end
  endtask

  task automatic test_async_reset;
    fill_random();
    ready = 1'b1;
    apply_reset();
    tick(); tick(); tick();
    ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || pc_addr !== 32'h0 || pc_out !== 32'h0 || instr_out !== 32'h0 || count !== 16'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_rst got v=%b pc_addr=%h pc=%h instr=%h cnt=%0d h=%b want all zero",
                         valid, pc_addr, pc_out, instr_out, count, halted);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || pc_addr !== 32'h0) begin
      errors++; $display("FAIL async_idle got v=%b pc_addr=%h want v=0 pc_addr=00000000", valid, pc_addr);
    end
    tick();
    checks++; if (valid !== 1'b1 || pc_out !== 32'h0 || instr_out !== mem[0]) begin
      errors++; $display("FAIL async_first got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=%h", valid, pc_out, instr_out, mem[0]);
    end
  endtask

  task automatic test_saturate;
    fill_random();
    ready = 1'b1;
    apply_reset();
    tick(); tick();
    force dut.fetch_count_reg = 16'hFFFE;
    #1;
    release dut.fetch_count_reg;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL sat%0d got %h want ffff", k, count); end
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc[$];
    logic [31:0] exp_instr[$];
    logic [31:0] halt_pc;
    int zpos, n_exp, cyc;
    for (int trial = 0; trial < 4; trial++) begin
      fill_random();
      zpos = $urandom_range(3, 40);
      if (zpos < 32) mem[zpos] = 32'h0;
      exp_pc.delete();
      exp_instr.delete();
      halt_pc = 32'h0;
      while (halt_pc < 32'd128 && mem[halt_pc[6:2]] != 32'h0) begin
        exp_pc.push_back(halt_pc);
        exp_instr.push_back(mem[halt_pc[6:2]]);
        halt_pc = halt_pc + 32'd4;
      end
      n_exp = exp_pc.size();
      ready = 1'($urandom_range(0, 1));
      apply_reset();
      cyc = 0;
      while (!(halted === 1'b1 && valid === 1'b0) && cyc < 600) begin
        ready = 1'($urandom_range(0, 1));
        if (valid === 1'b1 && ready) begin
          checks++;
          if (exp_pc.size() == 0) begin
            errors++; $display("FAIL rnd%0d_extra got pc=%h want no handoff", trial, pc_out);
          end else begin
            if (pc_out !== exp_pc[0] || instr_out !== exp_instr[0]) begin
              errors++; $display("FAIL rnd%0d_handoff got pc=%h instr=%h want pc=%h instr=%h",
                                 trial, pc_out, instr_out, exp_pc[0], exp_instr[0]);
            end else begin
              $display("handoff trial=%0d pc=%h instr=%h", trial, pc_out, instr_out);
            end
            void'(exp_pc.pop_front());
            void'(exp_instr.pop_front());
          end
        end
        tick();
        cyc++;
      end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rnd%0d_timeout got h=%b want 1", trial, halted); end
      checks++; if (exp_pc.size() != 0) begin errors++; $display("FAIL rnd%0d_missing got %0d left want 0", trial, exp_pc.size()); end
      checks++; if (count !== 16'(n_exp)) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", trial, count, n_exp); end
      checks++; if (pc_addr !== halt_pc) begin errors++; $display("FAIL rnd%0d_halt_pc got %h want %h", trial, pc_addr, halt_pc); end
    end
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b0;
    ready_s = 1'b1;
    redirect = 1'b0;
    redirect_s = 1'b0;
    redirect_pc = 32'h0;
    redirect_pc_s = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem_s[i] = 32'h1;
    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_small_range();
    test_async_reset();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
